// File: rtl/prim_fifo_sync_unpack.sv
// Synchronous width-down FIFO. It stores wide words and drains each one as narrow chunks,
// least-significant chunk first. Each word carries its own valid-chunk count.
module prim_fifo_sync_unpack #(
    parameter int unsigned InW    = 32,
    parameter int unsigned OutW   = 8,
    parameter int unsigned Depth  = 2,
    localparam int unsigned Ratio  = InW / OutW,
    localparam int unsigned CntW   = ((Ratio + 1) <= 1) ? 1 : $clog2(Ratio + 1),
    localparam int unsigned DepthW = ((Depth * Ratio + 1) <= 1) ? 1 : $clog2(Depth * Ratio + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [InW-1:0]    wdata_i,
    input  logic [CntW-1:0]   wcnt_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [OutW-1:0]   rdata_o,
    output logic              rlast_o,
    output logic              full_o,
    output logic [DepthW-1:0] depth_o,
    output logic              err_o
);

    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned WcountW = $clog2(Depth + 1);
    localparam int unsigned IdxW   = $clog2(Ratio);

    if (InW % OutW != 0) begin : gen_bad_width
        $error("InW must be an integer multiple of OutW");
    end
    if (Depth == 0) begin : gen_bad_depth
        $error("Depth must be at least 1");
    end
    if (Ratio < 2) begin : gen_bad_ratio
        $error("InW/OutW must be at least 2");
    end

    // Storage carries no reset; only the control state below is reset.
    logic [InW-1:0]     mem_data [Depth];
    logic [CntW-1:0]    mem_cnt  [Depth];

    logic [PtrW-1:0]    wptr_q, wptr_d;
    logic [PtrW-1:0]    rptr_q, rptr_d;
    logic [WcountW-1:0] wcount_q, wcount_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [DepthW-1:0]  depth_q, depth_d;
    logic               err_q, err_d;
    logic               under_rst_q;

    logic               accept;
    logic               pop;
    logic               cnt_bad;
    logic [CntW-1:0]    cnt_store;
    logic [CntW-1:0]    cur_cnt;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (Depth == 1) begin
            return '0;
        end
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Port-level handshakes and status, all derived from registered state.
    always_comb begin
        wready_o  = (wcount_q != WcountW'(Depth)) & ~under_rst_q;
        rvalid_o  = (wcount_q != '0) & ~under_rst_q;
        full_o    = (wcount_q == WcountW'(Depth));
        cur_cnt   = mem_cnt[rptr_q];
        rlast_o   = rvalid_o & (CntW'(idx_q) == (cur_cnt - CntW'(1)));
        // An out-of-range count still stores a full word.
        cnt_bad   = (wcnt_i == '0) | (wcnt_i > CntW'(Ratio));
        cnt_store = cnt_bad ? CntW'(Ratio) : wcnt_i;
        // A flush drops any transfer in the same cycle.
        accept    = wvalid_i & wready_o & ~clr_i;
        pop       = rvalid_o & rready_i & ~clr_i;
        depth_o   = depth_q;
        err_o     = err_q;
    end

    // Select the current chunk of the head word; zero when nothing is valid.
    always_comb begin
        rdata_o = '0;
        if (rvalid_o) begin
            rdata_o = mem_data[rptr_q][idx_q * OutW +: OutW];
        end
    end

    // Next-state for pointers, chunk index, counters and the error flag.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        wcount_d = wcount_q;
        idx_d    = idx_q;
        depth_d  = depth_q;
        err_d    = err_q;
        if (clr_i) begin
            wptr_d   = '0;
            rptr_d   = '0;
            wcount_d = '0;
            idx_d    = '0;
            depth_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (accept) begin
                wptr_d = ptr_inc(wptr_q);
            end
            if (pop) begin
                if (rlast_o) begin
                    idx_d  = '0;
                    rptr_d = ptr_inc(rptr_q);
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            if (accept && !(pop && rlast_o)) begin
                wcount_d = wcount_q + WcountW'(1);
            end else if (!accept && pop && rlast_o) begin
                wcount_d = wcount_q - WcountW'(1);
            end
            depth_d = depth_q + (accept ? DepthW'(cnt_store) : '0) - DepthW'(pop);
            err_d   = err_q | (accept & cnt_bad);
        end
    end

    // Control state register; under_rst_q blocks traffic for the first cycle after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            wcount_q    <= '0;
            idx_q       <= '0;
            depth_q     <= '0;
            err_q       <= 1'b0;
            under_rst_q <= 1'b1;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            wcount_q    <= wcount_d;
            idx_q       <= idx_d;
            depth_q     <= depth_d;
            err_q       <= err_d;
            under_rst_q <= 1'b0;
        end
    end

    // Word storage write.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_data[wptr_q] <= wdata_i;
            mem_cnt[wptr_q]  <= cnt_store;
        end
    end

endmodule

// File: tb/tb_prim_fifo_sync_unpack.sv
// Bench for prim_fifo_sync_unpack: chunk-queue reference model plus directed literal checks.
module tb_prim_fifo_sync_unpack;

    localparam int DEPTH = 2;
    localparam int RATIO = 4;

    logic        clk;
    logic        rst_ni;
    logic        clr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [2:0]  wcnt;
    logic        rvalid;
    logic        rready;
    logic [7:0]  rdata;
    logic        rlast;
    logic        full;
    logic [3:0]  depth;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    prim_fifo_sync_unpack #(
        .InW   (32),
        .OutW  (8),
        .Depth (DEPTH)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .clr_i    (clr),
        .wvalid_i (wvalid),
        .wready_o (wready),
        .wdata_i  (wdata),
        .wcnt_i   (wcnt),
        .rvalid_o (rvalid),
        .rready_i (rready),
        .rdata_o  (rdata),
        .rlast_o  (rlast),
        .full_o   (full),
        .depth_o  (depth),
        .err_o    (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a flat queue of pending chunks, each tagged with end-of-word.
    typedef struct {
        logic [7:0] d;
        bit         last;
    } chunk_t;

    chunk_t cq[$];
    bit     m_under;
    bit     m_err;

    function automatic int words();
        int n = 0;
        foreach (cq[i]) if (cq[i].last) n++;
        return n;
    endfunction

    initial begin
        int  w;
        int  n;
        bit  p;
        bit  a;
        bit  bad;
        m_under = 1'b1;
        m_err   = 1'b0;
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) begin
                cq.delete();
                m_under = 1'b1;
                m_err   = 1'b0;
            end else if (m_under) begin
                m_under = 1'b0;
            end else if (clr) begin
                cq.delete();
                m_err = 1'b0;
            end else begin
                w = words();
                p = (cq.size() > 0) && rready;
                a = wvalid && (w < DEPTH);
                if (p) void'(cq.pop_front());
                if (a) begin
                    bad = (wcnt == 0) || (int'(wcnt) > RATIO);
                    n   = bad ? RATIO : int'(wcnt);
                    if (bad) m_err = 1'b1;
                    for (int k = 0; k < n; k++) begin
                        cq.push_back('{d: wdata[8*k +: 8], last: (k == n - 1)});
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        bit         e_rv;
        logic [7:0] e_rd;
        bit         e_rl;
        forever begin
            @(negedge clk);
            e_rv = !m_under && (cq.size() > 0);
            e_rd = e_rv ? cq[0].d : 8'h00;
            e_rl = e_rv && cq[0].last;
            chk("cyc_wready", 64'(wready), 64'(!m_under && (words() < DEPTH)));
            chk("cyc_rvalid", 64'(rvalid), 64'(e_rv));
            chk("cyc_rdata", 64'(rdata), 64'(e_rd));
            chk("cyc_rlast", 64'(rlast), 64'(e_rl));
            chk("cyc_full", 64'(full), 64'(words() == DEPTH));
            chk("cyc_depth", 64'(depth), 64'(cq.size()));
            chk("cyc_err", 64'(err), 64'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] t1 [4];
        t1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rst_ni = 1'b0;
        clr    = 1'b0;
        wvalid = 1'b0;
        rready = 1'b0;
        wdata  = '0;
        wcnt   = 3'd4;
        @(negedge clk);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_depth", 64'(depth), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        cyc();

        // Full word, LSB chunk first.
        wvalid = 1'b1; wdata = 32'hDDCCBBAA; wcnt = 3'd4; rready = 1'b1;
        cyc();
        wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_rdata", 64'(rdata), 64'(t1[i]));
            chk("t1_depth", 64'(depth), 64'(4 - i));
            chk("t1_rlast", 64'(rlast), 64'(i == 3));
            cyc();
        end
        @(negedge clk);
        chk("t1_depth_end", 64'(depth), 64'd0);
        chk("t1_rvalid_end", 64'(rvalid), 64'd0);

        // Partial word.
        cyc();
        wvalid = 1'b1; wdata = 32'h44332211; wcnt = 3'd2;
        cyc();
        wvalid = 1'b0;
        @(negedge clk);
        chk("t2_rdata0", 64'(rdata), 64'h11);
        chk("t2_depth0", 64'(depth), 64'd2);
        cyc();
        @(negedge clk);
        chk("t2_rdata1", 64'(rdata), 64'h22);
        chk("t2_rlast1", 64'(rlast), 64'd1);
        cyc();
        @(negedge clk);
        chk("t2_depth_end", 64'(depth), 64'd0);

        // Fill, back-pressure, then free one slot.
        cyc();
        rready = 1'b0; wvalid = 1'b1; wdata = 32'h13121110; wcnt = 3'd4;
        cyc();
        wdata = 32'h23222120;
        cyc();
        wdata = 32'h33323130;
        @(negedge clk);
        chk("t3_full", 64'(full), 64'd1);
        chk("t3_wready", 64'(wready), 64'd0);
        chk("t3_depth", 64'(depth), 64'd8);
        cyc();
        rready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cyc();
            @(negedge clk);
            chk("t3_wready_hold", 64'(wready), 64'd0);
        end
        cyc();
        @(negedge clk);
        chk("t3_wready_free", 64'(wready), 64'd1);
        chk("t3_depth_free", 64'(depth), 64'd4);
        cyc();
        wvalid = 1'b0;
        repeat (10) cyc();

        // Write in the same cycle the last chunk of the only word pops.
        rready = 1'b0; wvalid = 1'b1; wdata = 32'h0000005A; wcnt = 3'd1;
        cyc();
        wvalid = 1'b0;
        @(negedge clk);
        chk("t4_depth_a", 64'(depth), 64'd1);
        chk("t4_rlast_a", 64'(rlast), 64'd1);
        cyc();
        wvalid = 1'b1; wdata = 32'h88776655; wcnt = 3'd4; rready = 1'b1;
        cyc();
        wvalid = 1'b0;
        @(negedge clk);
        chk("t4_full", 64'(full), 64'd0);
        chk("t4_depth_b", 64'(depth), 64'd4);
        chk("t4_rdata_b", 64'(rdata), 64'h55);
        repeat (6) cyc();

        // Flush mid-word drops the concurrent write.
        wvalid = 1'b1; wdata = 32'hC3C2C1C0; wcnt = 3'd4;
        cyc();
        wvalid = 1'b0;
        @(negedge clk);
        chk("t5_rdata_c0", 64'(rdata), 64'hC0);
        cyc();
        cyc();
        clr = 1'b1; wvalid = 1'b1; wdata = 32'hD3D2D1D0;
        cyc();
        clr = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("t5_rvalid_clr", 64'(rvalid), 64'd0);
        chk("t5_depth_clr", 64'(depth), 64'd0);
        cyc();
        wvalid = 1'b1; wdata = 32'hE3E2E1E0;
        cyc();
        wvalid = 1'b0;
        @(negedge clk);
        chk("t5_rdata_e0", 64'(rdata), 64'hE0);
        chk("t5_depth_e", 64'(depth), 64'd4);
        repeat (6) cyc();

        // Illegal count: full word emitted, sticky error until flush.
        wvalid = 1'b1; wdata = 32'hF3F2F1F0; wcnt = 3'd0;
        cyc();
        wvalid = 1'b0; wcnt = 3'd4;
        @(negedge clk);
        chk("t6_err", 64'(err), 64'd1);
        chk("t6_depth", 64'(depth), 64'd4);
        repeat (4) cyc();
        @(negedge clk);
        chk("t6_depth_end", 64'(depth), 64'd0);
        for (int j = 0; j < 10; j++) begin
            cyc();
            wvalid = 1'($urandom_range(0, 1));
            wdata  = $urandom;
            wcnt   = 3'($urandom_range(1, 4));
            @(negedge clk);
            chk("t6_err_sticky", 64'(err), 64'd1);
        end
        cyc();
        wvalid = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;
        @(negedge clk);
        chk("t6_err_clr", 64'(err), 64'd0);

        // Random traffic, occasional flush, one reset mid-stream.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            wvalid = 1'($urandom_range(0, 1));
            rready = ($urandom_range(0, 3) != 0);
            wdata  = $urandom;
            wcnt   = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7))
                                                   : 3'($urandom_range(1, 4));
            clr    = ($urandom_range(0, 63) == 0);
            if (i == 1500) begin
                rst_ni = 1'b0;
                cyc();
                cyc();
                rst_ni = 1'b1;
            end
        end
        cyc();
        wvalid = 1'b0; clr = 1'b0; rready = 1'b1;
        repeat (12) cyc();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prim_fifo_sync_unpack.md
Name: prim_fifo_sync_unpack

Overview:
Synchronous read-side width-down FIFO. It buffers wide words from a producer on a valid/ready port and drains them as narrow chunks on a second valid/ready port, least-significant chunk first. Each word carries a valid-chunk count, so a partial final word emits only its populated chunks. It sits between wide bus-side logic and narrow serial or byte-wise consumers, and complements the existing sync FIFO on the read side of width-converting datapaths.

Parameters:
InW, 32, input word width; must be an integer multiple of OutW (elaboration assertion otherwise).
OutW, 8, output chunk width.
Depth, 2, number of wide-word storage entries; must be >= 1 (elaboration error if 0).
Ratio (localparam), InW/OutW, chunks per word; must be >= 2.
CntW (localparam), vbits(Ratio+1), width of the chunk-count field.
DepthW (localparam), vbits(Depth*Ratio+1), width of depth_o.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clr_i  in  1  synchronous flush
wvalid_i  in  1  write word valid
wready_o  out  1  write word ready
wdata_i  in  InW  write word
wcnt_i  in  CntW  number of valid chunks in wdata_i (1..Ratio)
rvalid_o  out  1  chunk valid
rready_i  in  1  chunk ready
rdata_o  out  OutW  chunk data
rlast_o  out  1  current chunk is the last valid chunk of its word
full_o  out  1  all Depth word entries occupied
depth_o  out  DepthW  total pending output chunks
err_o  out  1  sticky illegal-wcnt flag

Behaviour:
- Reset values: wready_o=0, rvalid_o=0, rdata_o=0, rlast_o=0, full_o=0, depth_o=0, err_o=0. All pointers, counters and the chunk index are 0.
- under_rst flag: set by reset and cleared on the first clock after release. While it is set, wready_o=0 and rvalid_o=0, and no transfers occur.
- Storage: Depth entries, each holding {data[InW], cnt[CntW]}. Write and read pointers wrap from Depth-1 to 0. Word count wcount runs 0..Depth. The storage array has no reset; only the control state is reset.
- Write side:
  - wready_o = (wcount != Depth) & ~under_rst.
  - A word is accepted when wvalid_i & wready_o; it is stored at wptr and wptr advances.
  - wready_o depends only on registered state. There is no combinational path from rready_i to wready_o, so a slot freed in cycle N is writable in cycle N+1.
  - full_o = (wcount == Depth).
- Read side:
  - There is no pass-through. A word accepted in cycle N is first visible on the read port in cycle N+1.
  - rvalid_o = (wcount != 0) & ~under_rst.
  - rdata_o = entry[rptr].data[idx*OutW +: OutW] while rvalid_o=1, else 0.
  - rlast_o = rvalid_o & (idx == entry[rptr].cnt - 1).
  - On a pop (rvalid_o & rready_i):
    - If rlast_o: idx <= 0, rptr advances, and wcount decrements.
    - Otherwise: idx <= idx + 1.
  - Chunks beyond cnt are never emitted.
- Illegal wcnt_i: a value of 0 or a value > Ratio is still accepted. The stored cnt is forced to Ratio, and err_o is set the next cycle. err_o stays set until clr_i or reset.
- depth_o: a running chunk counter. Each cycle it updates as depth_o + (accepted ? stored_cnt : 0) - (pop ? 1 : 0). It never over- or underflows by construction.
- Simultaneous events:
  - Write together with a pop of a last chunk: wcount is unchanged and both pointers advance.
  - Write together with a non-last pop: wcount increments and idx increments.
- clr_i (synchronous, highest priority): wptr, rptr, idx, wcount, depth_o and err_o go to 0 next cycle. Any write or pop in the same cycle is dropped. clr_i does not assert under_rst.
- Reset mid-word: all control state returns to reset values immediately, and the partial word is discarded.
- Depth==1: pointers are unused and held at 0; a single entry is used.

Test Plan:
(InW=32, OutW=8, Depth=2 throughout)
1. After reset, write 0xDDCCBBAA with wcnt=4 and rready_i=1 held -> rdata_o is 0xAA, 0xBB, 0xCC, 0xDD on the 4 cycles starting the cycle after acceptance; rlast_o=1 only with 0xDD; depth_o reads 4,3,2,1,0.
2. Write 0x44332211 with wcnt=2 -> chunks 0x11 then 0x22, rlast_o on 0x22; 0x33 and 0x44 never appear; depth_o reads 2,1,0.
3. With rready_i=0, write 2 words (wcnt=4 each) -> full_o=1, wready_o=0, depth_o=8. A third wvalid_i is held off. Pop 3 chunks -> wready_o stays 0. Pop the 4th chunk -> wready_o=1 the following cycle, depth_o=4.
4. With wcount=1, write word B in the same cycle that the last chunk of word A pops -> full_o stays 0; depth_o goes 1->4 next cycle; the next rdata_o is B chunk 0.
5. After 2 of 4 chunks are popped, assert clr_i with wvalid_i=1 -> the write is dropped; next cycle rvalid_o=0, depth_o=0. A new word then emits from chunk 0.
6. Write with wcnt=0 -> err_o=1 next cycle and the word emits 4 chunks. err_o stays 1 across further traffic and returns to 0 only after clr_i.
